// File: rtl/mod997_pkg.sv
// Shared constants, FSM state type and helpers
// for the serial mod-997 reducer.
package mod997_pkg;

    localparam int MODULUS = 997;
    localparam int RES_W   = 10;
    localparam int CHUNK_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int step_count(
        input int n_bits,
        input int chunk
    );
        return n_bits / chunk;
    endfunction

endpackage

// File: rtl/mod997_serial_reducer_if.sv
// Operand/result valid-ready bundle for the
// serial mod-997 reducer.
interface mod997_serial_reducer_if #(
    parameter int N_BITS = 300
);
    import mod997_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_res;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_res
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_res
    );

endinterface

// File: rtl/mod997_step.sv
// One reduction step: (acc*64 + c) mod 997.
// acc*64 + c is exactly {acc, c}, at most 16 bits.
module mod997_step
    import mod997_pkg::*;
(
    input  logic [RES_W-1:0]   acc,
    input  logic [CHUNK_W-1:0] c,
    output logic [RES_W-1:0]   res
);

    logic [15:0] t;

    assign t   = {acc, c};
    assign res = RES_W'(t % 16'(MODULUS));

endmodule

// File: rtl/mod997_serial_reducer.sv
// Serial X mod 997, CHUNK bits per cycle, MSB first.
// Optional out_zero flag: define MOD997_ZERO_FLAG_EN.
module mod997_serial_reducer
    import mod997_pkg::*;
#(
    parameter int N_BITS = 300,
    parameter int CHUNK  = 6
) (
    input  logic clk,
    input  logic rst,
    mod997_serial_reducer_if.slave bus
`ifdef MOD997_ZERO_FLAG_EN
    ,
    output logic out_zero
`endif
);

    localparam int STEPS = step_count(N_BITS, CHUNK);
    localparam int CNT_W = $clog2(STEPS + 1);

    state_t            state_q;
    state_t            state_d;
    logic [N_BITS-1:0] sreg_q;
    logic [RES_W-1:0]  acc_q;
    logic [RES_W-1:0]  res_q;
    logic [RES_W-1:0]  step_res;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_step;
    logic              accept;

    assign last_step = (cnt_q == CNT_W'(STEPS - 1));
    assign accept    = (state_q == IDLE) && bus.in_valid;

    mod997_step u_step (
        .acc (acc_q),
        .c   (sreg_q[N_BITS-1 -: CHUNK]),
        .res (step_res)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load on acceptance, then one chunk per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
        end else if (accept) begin
            sreg_q <= bus.in_data;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (state_q == RUN) begin
            sreg_q <= sreg_q << CHUNK;
            acc_q  <= step_res;
            cnt_q  <= cnt_q + 1'b1;
            if (last_step) begin
                res_q <= step_res;
            end
        end
    end

    assign bus.out_res = res_q;

`ifdef MOD997_ZERO_FLAG_EN
    assign out_zero = !rst && bus.out_valid
                      && (res_q == '0);
`endif

endmodule

// File: doc/mod997_serial_reducer.md
MOD997_SERIAL_REDUCER -- requirements
Module: mod997_serial_reducer

Interface
REQ-001 SHALL have parameter N_BITS, default 300, meaning the operand width in bits; it SHALL be a multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 6, meaning the number of operand bits consumed per step.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1: the operand on in_data is valid.
REQ-006 SHALL have port in_ready, output, 1: the block can accept an operand.
REQ-007 SHALL have port in_data, input, N_BITS: the unsigned operand X.
REQ-008 SHALL have port out_valid, output, 1: out_res holds a valid result.
REQ-009 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-010 SHALL have port out_res, output, 10: X mod 997, in the range 0..996.

Function
REQ-011 SHALL compute out_res = X mod 997 exactly, for every X in 0..2^N_BITS-1.
REQ-012 SHALL use a three-state FSM: IDLE, RUN and DONE.
REQ-013 SHALL assert in_ready only in IDLE; out_valid SHALL be asserted only in DONE.
REQ-014 IDLE to RUN on in_valid and in_ready: load in_data into a shift register, set acc to 0 and cnt to 0.
REQ-015 In RUN, each cycle SHALL consume the most-significant remaining CHUNK bits c: acc <= (acc*64 + c) mod 997, shift the register left by CHUNK, cnt <= cnt+1.
REQ-016 acc SHALL stay in 0..996 after every step; the intermediate acc*64+c is at most 63807 (16 bits); no truncation is allowed.
REQ-017 RUN to DONE on the edge that performs step N_BITS/CHUNK (50 by default); out_valid SHALL rise exactly 50 cycles after the acceptance edge.
REQ-018 In DONE, out_res and out_valid SHALL hold stable while out_ready is low, with no cap on the wait.
REQ-019 DONE to IDLE on out_valid and out_ready; in_ready SHALL be high in the following cycle.
REQ-020 No operand is accepted in the DONE-to-IDLE cycle: this gives a throughput of 1 result per 52 cycles under continuous streaming.
REQ-021 in_valid and in_data SHALL be ignored outside IDLE; in_data is sampled only at acceptance.
REQ-022 out_res SHALL hold the last result, or 0 after reset, when out_valid is low.

Reset
REQ-023 On rst high at a clock edge: state SHALL go to IDLE; acc, cnt, the shift register and out_res SHALL go to 0; in_ready SHALL be 1 and out_valid 0 in the following cycle.
REQ-024 Reset during RUN or DONE SHALL abort the operation with no output produced.
REQ-025 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-026 Macro MOD997_ZERO_FLAG_EN: when defined, the block SHALL add output port out_zero (1 bit), equal to out_valid AND (out_res == 0); it SHALL be 0 during reset.
REQ-027 Without MOD997_ZERO_FLAG_EN, port out_zero and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package mod997_pkg SHALL hold: MODULUS = 997, RES_W = 10, CHUNK_W = 6, the state enum (IDLE, RUN, DONE), and the step count function N_BITS/CHUNK.
REQ-029 Sub-module mod997_step SHALL be combinational: inputs acc (10 bits) and c (6 bits), output (acc*64 + c) mod 997; mod997_serial_reducer SHALL instantiate it once.

Verification
REQ-030 Drive X=0 and hold out_ready=1: out_res=0, out_valid rises 50 cycles after acceptance, and out_zero=1 if enabled.
REQ-031 Drive X=996, 997, 1000 and 994014 in turn: out_res SHALL be 996, 0, 3 and 5 respectively.
REQ-032 Hold out_ready=0 for 20 cycles in DONE: out_valid and out_res stay stable and in_ready stays 0; after the handshake, in_ready is 1 on the next cycle.
REQ-033 Assert rst at cycle 25 of RUN: the next cycle shows in_ready=1 and out_valid=0, and a following X=64 returns 64.
REQ-034 Keep in_valid high with changing in_data during RUN: the result SHALL reflect only the operand sampled at acceptance.
REQ-035 Apply 1000 random 300-bit X values with random out_ready stalls and compare against a bignum model: zero mismatches are allowed.
